// File: rtl/mem_access_ctrl_pkg.sv
// Shared types, funct3 encodings and lane helpers for the memory access controller.
`default_nettype none

package mem_access_ctrl_pkg;

   localparam int cXLEN   = 32;
   localparam int cMemBeW = 4;

   localparam logic [2:0] cLb  = 3'd0;
   localparam logic [2:0] cLh  = 3'd1;
   localparam logic [2:0] cLw  = 3'd2;
   localparam logic [2:0] cLbu = 3'd4;
   localparam logic [2:0] cLhu = 3'd5;
   localparam logic [2:0] cSb  = 3'd0;
   localparam logic [2:0] cSh  = 3'd1;
   localparam logic [2:0] cSw  = 3'd2;

   typedef struct packed {
      logic [cXLEN-1:0] addr;
      logic [cXLEN-1:0] data;
      logic [4:0]       rdAddr;
      logic [2:0]       opType;
      logic             read;
      logic             write;
   } tMemOp;

   typedef struct packed {
      logic [4:0]       addr;
      logic [cXLEN-1:0] data;
      logic             dv;
   } tRegOp;

   typedef enum logic [1:0] {
      eIdle = 2'd0,
      eReq  = 2'd1,
      eWb   = 2'd2
   } tMemCtrlState;

   // Illegal funct3 or an access not aligned to its own size.
   function automatic logic op_is_bad(input logic isLoad, input logic [2:0] f3,
                                      input logic [1:0] a);
      logic bad;
      if (isLoad) bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      else        bad = (f3 >= 3'd3);
      case (f3[1:0])
         2'd1:    if (a[0])     bad = 1'b1;
         2'd2:    if (a != 2'd0) bad = 1'b1;
         default: ;
      endcase
      return bad;
   endfunction

   function automatic logic [cMemBeW-1:0] byte_en(input logic [1:0] size, input logic [1:0] a);
      logic [cMemBeW-1:0] be;
      case (size)
         2'd0:    be = 4'b0001 << a;
         2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [cXLEN-1:0] store_lanes(input logic [1:0] size,
                                                     input logic [cXLEN-1:0] d);
      logic [cXLEN-1:0] w;
      case (size)
         2'd0:    w = {4{d[7:0]}};
         2'd1:    w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   function automatic logic [cXLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                     input logic [cXLEN-1:0] rdata);
      logic [cXLEN-1:0] sh;
      logic [cXLEN-1:0] r;
      sh = rdata >> {a, 3'b000};
      case (f3)
         cLb:     r = {{24{sh[7]}}, sh[7:0]};
         cLh:     r = {{16{sh[15]}}, sh[15:0]};
         cLbu:    r = {24'd0, sh[7:0]};
         cLhu:    r = {16'd0, sh[15:0]};
         default: r = sh;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_op_fifo.sv
// Pending-op FIFO: power-of-two depth, generic payload type, occupancy count.
`default_nettype none

module mem_access_ctrl_op_fifo #(
   parameter int  pDepth = 4,
   parameter type tData  = logic [7:0]
) (
   input  logic                     iClk,
   input  logic                     iRst,
   input  logic                     iPush,
   input  tData                     iData,
   input  logic                     iPop,
   output tData                     oData,
   output logic                     oFull,
   output logic                     oEmpty,
   output logic [$clog2(pDepth):0]  oCount
);

   localparam int cAw = $clog2(pDepth);

   tData             mem_q [pDepth];
   logic [cAw-1:0]   wrPtr_q;
   logic [cAw-1:0]   rdPtr_q;
   logic [cAw:0]     count_q;
   logic             doPush;
   logic             doPop;

   assign oFull  = (count_q == (cAw+1)'(pDepth));
   assign oEmpty = (count_q == '0);
   assign oCount = count_q;
   assign oData  = mem_q[rdPtr_q];

   // A pop frees the slot before the push lands, so push-at-full with pop is accepted.
   assign doPop  = iPop && !oEmpty;
   assign doPush = iPush && (!oFull || doPop);

   always_ff @(posedge iClk) begin
      if (doPush) mem_q[wrPtr_q] <= iData;
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + cAw'(1);
         if (doPop)  rdPtr_q <= rdPtr_q + cAw'(1);
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + (cAw+1)'(1);
            2'b01:   count_q <= count_q - (cAw+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// Sequences buffered ALU load/store ops onto the single-ported data bus and
// returns extended load data to the register file.
`default_nettype none

module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int pDepth    = 4,
   parameter int pStallThr = 2
) (
   input  logic               iClk,
   input  logic               iRst,
   input  tMemOp              iMemOp,
   output logic               oStall,
   output logic               oMemReq,
   output logic               oMemWe,
   output logic [cXLEN-1:0]   oMemAddr,
   output logic [cMemBeW-1:0] oMemBe,
   output logic [cXLEN-1:0]   oMemWData,
   input  logic               iMemAck,
   input  logic [cXLEN-1:0]   iMemRData,
   output tRegOp              oRegWB,
   output logic               oFault,
   output logic [cXLEN-1:0]   oFaultAddr,
   output logic               oOverflow
);

   localparam int cCw = $clog2(pDepth) + 1;
   localparam logic [cCw-1:0] cThr = cCw'(pStallThr);

   tMemOp          head;
   logic           push;
   logic           pop;
   logic           full;
   logic           empty;
   logic [cCw-1:0] count;
   logic           headIsLoad;

   tMemCtrlState        state_q, state_d;
   logic                we_q, we_d;
   logic [cXLEN-1:0]    addr_q, addr_d;
   logic [cMemBeW-1:0]  be_q, be_d;
   logic [cXLEN-1:0]    wdata_q, wdata_d;
   logic [4:0]          rd_q, rd_d;
   logic [2:0]          f3_q, f3_d;
   logic [1:0]          boff_q, boff_d;
   logic [cXLEN-1:0]    wbData_q, wbData_d;
   logic                fault_q, fault_d;
   logic [cXLEN-1:0]    faultAddr_q, faultAddr_d;
   logic                stall_q;
   logic                ovf_q;

   assign push = iMemOp.read | iMemOp.write;

   mem_access_ctrl_op_fifo #(
      .pDepth (pDepth),
      .tData  (tMemOp)
   ) u_fifo (
      .iClk   (iClk),
      .iRst   (iRst),
      .iPush  (push),
      .iData  (iMemOp),
      .iPop   (pop),
      .oData  (head),
      .oFull  (full),
      .oEmpty (empty),
      .oCount (count)
   );

   // An op with read set is a load even when write is also set.
   assign headIsLoad = head.read | ~head.write;

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      rd_d        = rd_q;
      f3_d        = f3_q;
      boff_d      = boff_q;
      wbData_d    = wbData_q;
      fault_d     = 1'b0;
      faultAddr_d = faultAddr_q;
      pop         = 1'b0;
      unique case (state_q)
         eIdle: begin
            if (!empty) begin
               pop = 1'b1;
               if (op_is_bad(headIsLoad, head.opType, head.addr[1:0])) begin
                  fault_d     = 1'b1;
                  faultAddr_d = head.addr;
               end else begin
                  we_d    = ~headIsLoad;
                  addr_d  = {head.addr[cXLEN-1:2], 2'b00};
                  be_d    = byte_en(head.opType[1:0], head.addr[1:0]);
                  wdata_d = store_lanes(head.opType[1:0], head.data);
                  rd_d    = head.rdAddr;
                  f3_d    = head.opType;
                  boff_d  = head.addr[1:0];
                  state_d = eReq;
               end
            end
         end
         eReq: begin
            if (iMemAck) begin
               if (we_q) begin
                  state_d = eIdle;
               end else begin
                  wbData_d = load_extend(f3_q, boff_q, iMemRData);
                  state_d  = eWb;
               end
            end
         end
         eWb:     state_d = eIdle;
         default: state_d = eIdle;
      endcase
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q     <= eIdle;
         we_q        <= 1'b0;
         addr_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         rd_q        <= '0;
         f3_q        <= '0;
         boff_q      <= '0;
         wbData_q    <= '0;
         fault_q     <= 1'b0;
         faultAddr_q <= '0;
         stall_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         f3_q        <= f3_d;
         boff_q      <= boff_d;
         wbData_q    <= wbData_d;
         fault_q     <= fault_d;
         faultAddr_q <= faultAddr_d;
         stall_q     <= (count >= cThr);
         ovf_q       <= ovf_q | (push & full & ~pop);
      end
   end

   assign oStall      = stall_q;
   assign oMemReq     = (state_q == eReq);
   assign oMemWe      = we_q;
   assign oMemAddr    = addr_q;
   assign oMemBe      = be_q;
   assign oMemWData   = wdata_q;
   assign oRegWB.addr = rd_q;
   assign oRegWB.data = wbData_q;
   assign oRegWB.dv   = (state_q == eWb) && (rd_q != 5'd0);
   assign oFault      = fault_q;
   assign oFaultAddr  = faultAddr_q;
   assign oOverflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected bus/write-back/fault events are
// queued when ops are driven and popped as the DUT produces them.
`default_nettype none

module tb_mem_access_ctrl;
   import mem_access_ctrl_pkg::*;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
   } bus_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_t;

   logic        iClk = 1'b0;
   logic        iRst = 1'b0;
   tMemOp       iMemOp;
   logic        oStall;
   logic        oMemReq;
   logic        oMemWe;
   logic [31:0] oMemAddr;
   logic [3:0]  oMemBe;
   logic [31:0] oMemWData;
   logic        iMemAck = 1'b0;
   logic [31:0] iMemRData = '0;
   tRegOp       oRegWB;
   logic        oFault;
   logic [31:0] oFaultAddr;
   logic        oOverflow;

   bus_t        bus_q[$];
   wb_t         wb_q[$];
   logic [31:0] fault_q[$];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_ack_cyc = 0;
   int wait_cnt = 0;
   bit ack_en = 1'b1;

   mem_access_ctrl #(.pDepth(4), .pStallThr(2)) dut (
      .iClk       (iClk),
      .iRst       (iRst),
      .iMemOp     (iMemOp),
      .oStall     (oStall),
      .oMemReq    (oMemReq),
      .oMemWe     (oMemWe),
      .oMemAddr   (oMemAddr),
      .oMemBe     (oMemBe),
      .oMemWData  (oMemWData),
      .iMemAck    (iMemAck),
      .iMemRData  (iMemRData),
      .oRegWB     (oRegWB),
      .oFault     (oFault),
      .oFaultAddr (oFaultAddr),
      .oOverflow  (oOverflow)
   );

   always #5 iClk = ~iClk;
   always @(posedge iClk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Bus responder and output monitor, evaluated mid-cycle.
   always @(negedge iClk) begin
      if (!iRst) begin
         iMemAck  = 1'b0;
         wait_cnt = 0;
      end else begin
         if (oRegWB.dv) begin
            if (wb_q.size() == 0) check("wb_unexpected", oRegWB.dv, 0);
            else begin
               wb_t w;
               w = wb_q.pop_front();
               check("wb_rd", oRegWB.addr, w.rd);
               check("wb_data", oRegWB.data, w.data);
               check("wb_latency", cyc, last_ack_cyc + 1);
            end
         end
         if (oFault) begin
            if (fault_q.size() == 0) check("fault_unexpected", oFault, 0);
            else check("fault_addr", oFaultAddr, fault_q.pop_front());
         end
         iMemAck = 1'b0;
         if (oMemReq) begin
            if (bus_q.size() == 0) check("req_unexpected", oMemReq, 0);
            else if (ack_en && wait_cnt >= bus_q[0].delay) begin
               bus_t b;
               b = bus_q.pop_front();
               check("bus_we", oMemWe, b.we);
               check("bus_addr", oMemAddr, b.addr);
               check("bus_be", oMemBe, b.be);
               if (b.we) check("bus_wdata", oMemWData, b.wdata);
               iMemRData    = b.rdata;
               iMemAck      = 1'b1;
               last_ack_cyc = cyc;
               wait_cnt     = 0;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   task automatic exp_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
      bus_t b;
      b.we = we; b.addr = addr; b.be = be; b.wdata = wdata; b.rdata = rdata; b.delay = delay;
      bus_q.push_back(b);
   endtask

   task automatic exp_wb(input logic [4:0] rd, input logic [31:0] data);
      wb_t w;
      w.rd = rd; w.data = data;
      wb_q.push_back(w);
   endtask

   // Called at a falling edge; holds the op for exactly one rising edge.
   task automatic push_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd);
      iMemOp.addr   = addr;
      iMemOp.data   = data;
      iMemOp.rdAddr = rd;
      iMemOp.opType = f3;
      iMemOp.read   = ld;
      iMemOp.write  = ~ld;
      @(negedge iClk);
   endtask

   task automatic clear_op();
      iMemOp.read  = 1'b0;
      iMemOp.write = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while ((bus_q.size() + wb_q.size() + fault_q.size()) != 0 && k < budget) begin
         @(negedge iClk);
         #1;
         k++;
      end
      check("drain_timeout", bus_q.size() + wb_q.size() + fault_q.size(), 0);
      bus_q.delete();
      wb_q.delete();
      fault_q.delete();
      repeat (3) @(negedge iClk);
   endtask

   initial begin
      iMemOp = '0;
      repeat (3) @(negedge iClk);
      check("rst_outputs", {oStall, oMemReq, oMemWe, oMemBe, oFault, oOverflow, oRegWB.dv}, 0);
      check("rst_addr", {oMemAddr, oFaultAddr}, 0);
      iRst = 1'b1;
      @(negedge iClk);

      // LW with delayed ack; write-back must follow the ack by one cycle
      exp_bus(1'b0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 3);
      exp_wb(5'd5, 32'hDEADBEEF);
      push_op(1'b1, cLw, 32'h100, 32'h0, 5'd5); clear_op();
      wait_drain(40);

      // sign/zero extension across lanes
      exp_bus(1'b0, 32'h100, 4'b1000, 32'h0, 32'h80123456, 0);
      exp_wb(5'd6, 32'hFFFFFF80);
      push_op(1'b1, cLb, 32'h103, 32'h0, 5'd6); clear_op();
      wait_drain(40);
      exp_bus(1'b0, 32'h100, 4'b1000, 32'h0, 32'h80123456, 0);
      exp_wb(5'd7, 32'h00000080);
      push_op(1'b1, cLbu, 32'h103, 32'h0, 5'd7); clear_op();
      wait_drain(40);
      exp_bus(1'b0, 32'h100, 4'b1100, 32'h0, 32'h80017777, 1);
      exp_wb(5'd8, 32'hFFFF8001);
      push_op(1'b1, cLh, 32'h102, 32'h0, 5'd8); clear_op();
      wait_drain(40);
      exp_bus(1'b0, 32'h100, 4'b1100, 32'h0, 32'h80017777, 0);
      exp_wb(5'd9, 32'h00008001);
      push_op(1'b1, cLhu, 32'h102, 32'h0, 5'd9); clear_op();
      wait_drain(40);

      // stores: lane replication, no write-back
      exp_bus(1'b1, 32'h200, 4'b0010, 32'hABABABAB, 32'h0, 2);
      push_op(1'b0, cSb, 32'h201, 32'h000000AB, 5'd3); clear_op();
      wait_drain(40);
      exp_bus(1'b1, 32'h200, 4'b1100, 32'h12341234, 32'h0, 0);
      push_op(1'b0, cSh, 32'h202, 32'hFFFF1234, 5'd0); clear_op();
      wait_drain(40);

      // load to x0 still accesses the bus but produces no write-back pulse
      exp_bus(1'b0, 32'h104, 4'b1111, 32'h0, 32'h55555555, 0);
      push_op(1'b1, cLw, 32'h104, 32'h0, 5'd0); clear_op();
      wait_drain(40);

      // faults: misaligned SW, misaligned LH, illegal load funct3
      fault_q.push_back(32'h102);
      fault_q.push_back(32'h101);
      fault_q.push_back(32'h400);
      push_op(1'b0, cSw, 32'h102, 32'h0, 5'd1);
      push_op(1'b1, cLh, 32'h101, 32'h0, 5'd2);
      push_op(1'b1, 3'd3, 32'h400, 32'h0, 5'd3);
      clear_op();
      wait_drain(40);
      check("fault_addr_held", oFaultAddr, 32'h400);

      // back-pressure and overflow: first op sits in eReq, four fill the FIFO, sixth drops
      ack_en = 1'b0;
      check("ovf_before", oOverflow, 0);
      for (int i = 0; i < 5; i++) begin
         exp_bus(1'b0, 32'h300 + 32'(4*i), 4'b1111, 32'h0, 32'h1000 + 32'(i), 0);
         exp_wb(5'(10 + i), 32'h1000 + 32'(i));
      end
      push_op(1'b1, cLw, 32'h300, 32'h0, 5'd10);
      check("stall_low_occ1", oStall, 0);
      for (int i = 1; i < 5; i++) push_op(1'b1, cLw, 32'h300 + 32'(4*i), 32'h0, 5'(10 + i));
      check("ovf_not_yet", oOverflow, 0);
      push_op(1'b1, cLw, 32'h314, 32'h0, 5'd15);
      clear_op();
      check("ovf_set", oOverflow, 1);
      check("stall_high", oStall, 1);
      repeat (3) @(negedge iClk);
      ack_en = 1'b1;
      wait_drain(100);
      check("stall_after_drain", oStall, 0);
      check("ovf_sticky", oOverflow, 1);

      // reset in the middle of a bus request
      ack_en = 1'b0;
      exp_bus(1'b0, 32'h600, 4'b1111, 32'h0, 32'h0, 0);
      push_op(1'b1, cLw, 32'h600, 32'h0, 5'd4); clear_op();
      begin
         int k;
         k = 0;
         while (!oMemReq && k < 20) begin @(negedge iClk); k++; end
         check("req_before_reset", oMemReq, 1);
      end
      iRst = 1'b0;
      #1;
      check("rst_mid_ctrl", {oStall, oMemReq, oMemWe, oMemBe, oFault, oOverflow}, 0);
      check("rst_mid_data", {oMemAddr, oMemWData}, 0);
      check("rst_mid_wb", {oRegWB.addr, oRegWB.data, oRegWB.dv}, 0);
      check("rst_mid_faddr", oFaultAddr, 0);
      bus_q.delete();
      @(negedge iClk);
      iRst = 1'b1;
      ack_en = 1'b1;
      repeat (2) @(negedge iClk);
      exp_bus(1'b0, 32'h500, 4'b1111, 32'h0, 32'hCAFEF00D, 1);
      exp_wb(5'd7, 32'hCAFEF00D);
      push_op(1'b1, cLw, 32'h500, 32'h0, 5'd7); clear_op();
      wait_drain(40);
      check("ovf_after_reset", oOverflow, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
